// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bus for the UART transmit arbiter.
// The arbiter takes the slave modport. The environment driving requests and the transmitter takes the master modport.
interface uart_tx_arbiter_if;
   logic [3:0]  i_Req_Valid;
   logic [31:0] i_Req_Data;
   logic [3:0]  i_Req_Last;
   logic [3:0]  o_Req_Ready;
   logic        o_Tx_Start;
   logic [7:0]  o_Tx_Byte;
   logic        i_Tx_Busy;
   logic        i_Tx_Done;
   logic        o_Grant_Valid;
   logic [1:0]  o_Grant_Id;
   logic        o_Timeout;

   modport master (
      output i_Req_Valid, i_Req_Data, i_Req_Last, i_Tx_Busy, i_Tx_Done,
      input  o_Req_Ready, o_Tx_Start, o_Tx_Byte, o_Grant_Valid, o_Grant_Id, o_Timeout
   );

   modport slave (
      input  i_Req_Valid, i_Req_Data, i_Req_Last, i_Tx_Busy, i_Tx_Done,
      output o_Req_Ready, o_Tx_Start, o_Tx_Byte, o_Grant_Valid, o_Grant_Id, o_Timeout
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among four byte-stream requesters.
// A grant lasts until end-of-packet, burst cap, withdrawal or done-timeout.
module uart_tx_arbiter #(
   parameter int MAX_BURST    = 8,
   parameter int DONE_TIMEOUT = 4095
) (
   input  logic              clk,
   input  logic              reset_n,
   uart_tx_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [1:0]  r_rr_ptr;
   logic [1:0]  r_grant_id;
   logic        r_grant_valid;
   logic [7:0]  r_tx_byte;
   logic        r_tx_start;
   logic        r_last;
   logic [7:0]  r_burst;
   logic [15:0] r_wait_cnt;
   logic        r_timeout;

   logic [3:0]  w_rot_valid;
   logic [7:0]  w_req_byte [4];
   logic [1:0]  w_offset;
   logic [1:0]  w_winner;
   logic        w_any_valid;
   logic        w_owner_valid;
   logic        w_grant;
   logic        w_capture;
   logic        w_withdraw;
   logic        w_done_ok;
   logic        w_end_burst;
   logic        w_fire_timeout;
   logic        w_release;
   logic        w_illegal;
   logic [3:0]  w_req_ready;

   // Valid bits rotated so that index 0 is the requester just after the last released one.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_req
         logic [1:0] w_idx;
         assign w_idx          = r_rr_ptr + 2'(gi + 1);
         assign w_rot_valid[gi] = bus.i_Req_Valid[w_idx];
         assign w_req_byte[gi]  = bus.i_Req_Data[8*gi +: 8];
      end
   endgenerate

   always_comb begin
      w_offset = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (w_rot_valid[i]) begin
            w_offset = 2'(i);
         end
      end
   end

   assign w_winner      = r_rr_ptr + 2'd1 + w_offset;
   assign w_any_valid   = |bus.i_Req_Valid;
   assign w_owner_valid = bus.i_Req_Valid[r_grant_id];
   assign w_illegal     = !(r_state inside {S_IDLE, S_SEND, S_WAIT});

   assign w_grant     = (r_state == S_IDLE) && w_any_valid && !bus.i_Tx_Busy;
   assign w_capture   = (r_state == S_SEND) && w_owner_valid;
   assign w_withdraw  = (r_state == S_SEND) && !w_owner_valid;
   // A done pulse coincident with our own start pulse belongs to an earlier frame.
   assign w_done_ok   = (r_state == S_WAIT) && bus.i_Tx_Done && !r_tx_start;
   assign w_end_burst = r_last || (r_burst == 8'(MAX_BURST));
   assign w_fire_timeout = (r_state == S_WAIT) && !w_done_ok
                           && (r_wait_cnt == 16'(DONE_TIMEOUT - 1));
   assign w_release   = w_withdraw || (w_done_ok && w_end_burst) || w_fire_timeout;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_grant) begin
               w_state_next = S_SEND;
            end
         end
         S_SEND: begin
            w_state_next = w_capture ? S_WAIT : S_IDLE;
         end
         S_WAIT: begin
            if (w_release) begin
               w_state_next = S_IDLE;
            end else if (w_done_ok) begin
               w_state_next = S_SEND;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_comb begin
      w_req_ready = 4'd0;
      if (r_state == S_SEND) begin
         w_req_ready[r_grant_id] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rr_ptr      <= 2'd3;
         r_grant_id    <= 2'd0;
         r_grant_valid <= 1'b0;
         r_tx_byte     <= 8'h00;
         r_tx_start    <= 1'b0;
         r_last        <= 1'b0;
         r_burst       <= 8'd0;
         r_wait_cnt    <= 16'd0;
         r_timeout     <= 1'b0;
      end else begin
         r_tx_start <= w_capture;
         r_timeout  <= w_fire_timeout;
         if (w_grant) begin
            r_grant_id    <= w_winner;
            r_grant_valid <= 1'b1;
            r_burst       <= 8'd0;
         end
         if (w_capture) begin
            r_tx_byte  <= w_req_byte[r_grant_id];
            r_last     <= bus.i_Req_Last[r_grant_id];
            r_wait_cnt <= 16'd0;
            if (r_burst != 8'(MAX_BURST)) begin
               r_burst <= r_burst + 8'd1;
            end
         end
         if ((r_state == S_WAIT) && !w_done_ok && !w_release) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
         end
         if (w_release) begin
            r_rr_ptr      <= r_grant_id;
            r_grant_valid <= 1'b0;
         end
         if (w_illegal) begin
            r_grant_valid <= 1'b0;
         end
      end
   end

   assign bus.o_Req_Ready   = w_req_ready;
   assign bus.o_Tx_Start    = r_tx_start;
   assign bus.o_Tx_Byte     = r_tx_byte;
   assign bus.o_Grant_Valid = r_grant_valid;
   assign bus.o_Grant_Id    = r_grant_id;
   assign bus.o_Timeout     = r_timeout;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed protocol steps, then randomized request queues.
// The queues are compared against a transaction-order reference model.
module tb_uart_tx_arbiter;
   localparam int MAX_BURST    = 8;
   localparam int DONE_TIMEOUT = 10;
   localparam int QDEPTH       = 64;
   localparam int BUDGET       = 3000;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   uart_tx_arbiter_if bus ();

   uart_tx_arbiter #(.MAX_BURST(MAX_BURST), .DONE_TIMEOUT(DONE_TIMEOUT)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Per-requester byte queues, entry = {last, data}
   logic [8:0] qmem [4][QDEPTH];
   int         qhead [4];
   int         qtail [4];
   logic [9:0] exp_q [$];            // expected transmissions {id, byte}
   int         grant_order [$];
   int         starts_per_grant [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.i_Req_Valid = 4'd0;
      bus.i_Req_Data  = 32'd0;
      bus.i_Req_Last  = 4'd0;
      bus.i_Tx_Busy   = 1'b0;
      bus.i_Tx_Done   = 1'b0;
   endtask

   task automatic reset_dut();
      idle_inputs();
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_gv"},      bus.o_Grant_Valid, 0);
      check({tag, "_gid"},     bus.o_Grant_Id, 0);
      check({tag, "_ready"},   bus.o_Req_Ready, 0);
      check({tag, "_start"},   bus.o_Tx_Start, 0);
      check({tag, "_byte"},    bus.o_Tx_Byte, 8'h00);
      check({tag, "_timeout"}, bus.o_Timeout, 0);
   endtask

   task automatic clear_queues();
      for (int k = 0; k < 4; k++) begin
         qhead[k] = 0;
         qtail[k] = 0;
      end
      exp_q.delete();
      grant_order.delete();
      starts_per_grant.delete();
   endtask

   task automatic push_byte(input int k, input logic [7:0] d, input logic l);
      if (qtail[k] < QDEPTH) begin
         qmem[k][qtail[k]] = {l, d};
         qtail[k]++;
      end
   endtask

   // Reference: grant goes to the first non-empty queue after the last owner; the owner sends
   // until a last byte, MAX_BURST bytes, or its queue runs dry.
   task automatic build_expected();
      int h [4];
      int ptr;
      int idx;
      int n;
      bit stop;
      bit more;
      logic [8:0] ent;
      for (int k = 0; k < 4; k++) h[k] = qhead[k];
      ptr  = 3;
      more = 1'b1;
      while (more) begin
         idx = -1;
         for (int i = 1; i <= 4; i++) begin
            if (idx < 0 && h[(ptr + i) % 4] < qtail[(ptr + i) % 4]) idx = (ptr + i) % 4;
         end
         if (idx < 0) begin
            more = 1'b0;
         end else begin
            n    = 0;
            stop = 1'b0;
            while (!stop && h[idx] < qtail[idx] && n < MAX_BURST) begin
               ent = qmem[idx][h[idx]];
               h[idx]++;
               n++;
               exp_q.push_back({idx[1:0], ent[7:0]});
               if (ent[8]) stop = 1'b1;
            end
            ptr = idx;
         end
      end
   endtask

   // Acts as requesters and transmitter, checking every start against the reference order.
   task automatic run_queues(input string tag, input bit rand_busy);
      logic [3:0] acc_prev  = 4'd0;
      logic [3:0] own_mask;
      logic [9:0] e;
      logic [8:0] ent;
      logic       prev_gv   = 1'b0;
      logic       prev_busy = 1'b0;
      bit         awaiting  = 1'b0;
      int         done_cnt  = 0;
      int         cycles    = 0;
      bit         finished  = 1'b0;
      build_expected();
      while (!finished) begin
         step();
         cycles++;
         for (int k = 0; k < 4; k++) if (acc_prev[k]) qhead[k]++;
         own_mask = bus.o_Grant_Valid ? (4'b0001 << bus.o_Grant_Id) : 4'b0000;
         check("ready_owner", bus.o_Req_Ready & ~own_mask, 0);
         check("no_timeout", bus.o_Timeout, 0);
         if (bus.o_Grant_Valid && !prev_gv) begin
            check("grant_while_busy", prev_busy, 0);
            grant_order.push_back(int'(bus.o_Grant_Id));
            starts_per_grant.push_back(0);
         end
         if (bus.o_Tx_Start) begin
            check("start_while_wait", awaiting, 0);
            check("start_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("start_id", bus.o_Grant_Id, e[9:8]);
               check("start_byte", bus.o_Tx_Byte, e[7:0]);
               check("start_handshake", acc_prev, 4'b0001 << e[9:8]);
            end
            if (starts_per_grant.size() != 0)
               starts_per_grant[starts_per_grant.size() - 1] =
                  starts_per_grant[starts_per_grant.size() - 1] + 1;
         end
         prev_gv = bus.o_Grant_Valid;
         bus.i_Tx_Done = 1'b0;
         if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) begin
               bus.i_Tx_Done = 1'b1;
               awaiting      = 1'b0;
            end
         end
         if (bus.o_Tx_Start) begin
            awaiting = 1'b1;
            done_cnt = $urandom_range(1, 6);
            if ($urandom_range(0, 3) == 0) bus.i_Tx_Done = 1'b1;
         end
         bus.i_Tx_Busy = rand_busy && !bus.o_Grant_Valid && ($urandom_range(0, 2) == 0);
         prev_busy     = bus.i_Tx_Busy;
         for (int k = 0; k < 4; k++) begin
            if (qhead[k] < qtail[k]) begin
               ent = qmem[k][qhead[k]];
               bus.i_Req_Valid[k]       = 1'b1;
               bus.i_Req_Data[8*k +: 8] = ent[7:0];
               bus.i_Req_Last[k]        = ent[8];
            end else begin
               bus.i_Req_Valid[k]       = 1'b0;
               bus.i_Req_Data[8*k +: 8] = 8'h00;
               bus.i_Req_Last[k]        = 1'b0;
            end
         end
         acc_prev = bus.o_Req_Ready & bus.i_Req_Valid;
         finished = (exp_q.size() == 0 && !bus.o_Grant_Valid && !awaiting) || cycles >= BUDGET;
      end
      check({tag, "_budget"}, cycles < BUDGET, 1);
      check({tag, "_drained"}, exp_q.size(), 0);
      $display("phase %s: %0d cycles, %0d grants", tag, cycles, grant_order.size());
      idle_inputs();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired observed=hang expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  fair_exp [5];
      int  b2_exp [3];
      int  npk;
      int  len;
      logic bad;

      fair_exp = '{0, 1, 2, 3, 0};
      b2_exp   = '{2, 3, 2};

      idle_inputs();
      reset_n = 1'b0;
      step();
      step();
      check_reset_values("reset");
      reset_n = 1'b1;

      // Single byte from requester 1
      bus.i_Req_Valid = 4'b0010;
      bus.i_Req_Data  = 32'h0000_A500;
      bus.i_Req_Last  = 4'b0010;
      step();
      check("sb_c1_gv", bus.o_Grant_Valid, 1);
      check("sb_c1_gid", bus.o_Grant_Id, 1);
      check("sb_c1_ready", bus.o_Req_Ready, 4'b0010);
      check("sb_c1_start", bus.o_Tx_Start, 0);
      step();
      check("sb_c2_start", bus.o_Tx_Start, 1);
      check("sb_c2_byte", bus.o_Tx_Byte, 8'hA5);
      check("sb_c2_ready", bus.o_Req_Ready, 0);
      bus.i_Req_Valid = 4'b0000;
      step();
      check("sb_c3_start", bus.o_Tx_Start, 0);
      check("sb_c3_gv", bus.o_Grant_Valid, 1);
      check("sb_c3_byte", bus.o_Tx_Byte, 8'hA5);
      bus.i_Tx_Done = 1'b1;
      step();
      bus.i_Tx_Done = 1'b0;
      check("sb_c4_gv", bus.o_Grant_Valid, 0);
      check("sb_c4_byte", bus.o_Tx_Byte, 8'hA5);
      $display("single byte done");

      // Fairness: all four valid with single-byte packets
      reset_dut();
      clear_queues();
      push_byte(0, 8'h10, 1'b1);
      push_byte(0, 8'h11, 1'b1);
      push_byte(1, 8'h20, 1'b1);
      push_byte(2, 8'h30, 1'b1);
      push_byte(3, 8'h40, 1'b1);
      run_queues("fair", 1'b0);
      for (int i = 0; i < 5; i++)
         check("fair_order", (i < grant_order.size()) ? grant_order[i] : -1, fair_exp[i]);

      // Burst cap: requester 2 streams 12 bytes with no end-of-packet
      reset_dut();
      clear_queues();
      for (int i = 0; i < 12; i++) push_byte(2, 8'(8'h80 + i), 1'b0);
      run_queues("burst", 1'b0);
      check("burst_grants", grant_order.size(), 2);
      check("burst_first_len", (starts_per_grant.size() > 0) ? starts_per_grant[0] : -1, MAX_BURST);
      check("burst_second_len", (starts_per_grant.size() > 1) ? starts_per_grant[1] : -1, 4);

      // Burst cap with a competitor: requester 3 gets in between
      reset_dut();
      clear_queues();
      for (int i = 0; i < 12; i++) push_byte(2, 8'(8'hC0 + i), 1'b0);
      push_byte(3, 8'h3F, 1'b1);
      run_queues("burst2", 1'b0);
      for (int i = 0; i < 3; i++)
         check("burst2_order", (i < grant_order.size()) ? grant_order[i] : -1, b2_exp[i]);

      // Timeout: done never arrives
      reset_dut();
      bus.i_Req_Valid = 4'b0001;
      bus.i_Req_Data  = 32'h0000_003C;
      bus.i_Req_Last  = 4'b0001;
      step();
      step();
      check("to_start", bus.o_Tx_Start, 1);
      bus.i_Req_Valid = 4'b0000;
      bad = 1'b0;
      for (int i = 0; i < DONE_TIMEOUT - 1; i++) begin
         step();
         if (bus.o_Timeout || !bus.o_Grant_Valid) bad = 1'b1;
      end
      check("to_early", bad, 0);
      step();
      check("to_pulse", bus.o_Timeout, 1);
      check("to_release", bus.o_Grant_Valid, 0);
      step();
      check("to_pulse_end", bus.o_Timeout, 0);
      $display("timeout done");

      // Withdrawal of requester 3 during SEND
      reset_dut();
      bus.i_Req_Valid = 4'b1000;
      bus.i_Req_Data  = 32'h7700_0000;
      bus.i_Req_Last  = 4'b1000;
      step();
      check("wd_gid", bus.o_Grant_Id, 3);
      check("wd_ready", bus.o_Req_Ready, 4'b1000);
      bus.i_Req_Valid = 4'b0000;
      step();
      check("wd_release", bus.o_Grant_Valid, 0);
      check("wd_no_start", bus.o_Tx_Start, 0);
      // Busy holds off arbitration
      bus.i_Tx_Busy   = 1'b1;
      bus.i_Req_Valid = 4'b0100;
      bus.i_Req_Last  = 4'b0100;
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (bus.o_Grant_Valid || bus.o_Tx_Start) bad = 1'b1;
      end
      check("busy_no_grant", bad, 0);
      bus.i_Tx_Busy = 1'b0;
      step();
      check("busy_grant_gv", bus.o_Grant_Valid, 1);
      check("busy_grant_gid", bus.o_Grant_Id, 2);
      // Requester 2 withdraws, so it loses priority to 3 over 0
      bus.i_Req_Valid = 4'b1001;
      bus.i_Req_Last  = 4'b1001;
      step();
      check("wd2_release", bus.o_Grant_Valid, 0);
      step();
      check("rr_after_wd_gid", bus.o_Grant_Id, 3);
      bus.i_Req_Valid = 4'b0000;
      step();
      idle_inputs();
      $display("withdraw/busy done");

      // Reset asserted while waiting for done
      reset_dut();
      bus.i_Req_Valid = 4'b0010;
      bus.i_Req_Data  = 32'h0000_5A00;
      bus.i_Req_Last  = 4'b0010;
      step();
      step();
      check("rw_start", bus.o_Tx_Start, 1);
      bus.i_Req_Valid = 4'b0000;
      step();
      reset_n = 1'b0;
      step();
      check_reset_values("rst_mid");
      reset_n       = 1'b1;
      bus.i_Tx_Done = 1'b1;
      step();
      bus.i_Tx_Done = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (bus.o_Tx_Start || bus.o_Grant_Valid) bad = 1'b1;
      end
      check("rw_quiet", bad, 0);
      bus.i_Req_Valid = 4'b0101;
      bus.i_Req_Last  = 4'b0101;
      step();
      check("rw_regrant_gid", bus.o_Grant_Id, 0);
      bus.i_Req_Valid = 4'b0000;
      step();
      idle_inputs();
      $display("reset mid-wait done");

      // Randomized queues with random busy
      for (int r = 0; r < 3; r++) begin
         reset_dut();
         clear_queues();
         for (int k = 0; k < 4; k++) begin
            npk = $urandom_range(0, 3);
            for (int p = 0; p < npk; p++) begin
               len = $urandom_range(1, 12);
               for (int b = 0; b < len; b++)
                  push_byte(k, 8'($urandom_range(0, 255)), (b == len - 1) ? 1'b1 : 1'b0);
            end
         end
         run_queues("rand", 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: MAX_BURST, default 8, max bytes one requester may send per grant (range 1..255).
REQ-002 Parameter: DONE_TIMEOUT, default 4095, max clk cycles to wait for i_Tx_Done after o_Tx_Start (range 1..65535).
REQ-003 Port: clk  input  1  clock, all logic on rising edge.
REQ-004 Port: reset_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: i_Req_Valid  input  4  per-requester byte-valid; requester SHALL hold it and its data/last stable until ready.
REQ-006 Port: i_Req_Data  input  32  requester k byte on bits [8k+7:8k].
REQ-007 Port: i_Req_Last  input  4  per-requester end-of-packet flag qualifying the offered byte.
REQ-008 Port: o_Req_Ready  output  4  one-hot acceptance strobe; byte transferred when valid and ready are both high.
REQ-009 Port: o_Tx_Start  output  1  one-cycle pulse to the shared UART transmitter.
REQ-010 Port: o_Tx_Byte  output  8  byte to transmit, registered.
REQ-011 Port: i_Tx_Busy  input  1  transmitter busy; no new grant is issued while high.
REQ-012 Port: i_Tx_Done  input  1  one-cycle pulse when the transmitter finishes a frame.
REQ-013 Port: o_Grant_Valid  output  1  high while a requester owns the transmitter.
REQ-014 Port: o_Grant_Id  output  2  index of the owning requester, valid only when o_Grant_Valid is high.
REQ-015 Port: o_Timeout  output  1  one-cycle pulse when DONE_TIMEOUT expires.

Function
REQ-016 States: IDLE, SEND, WAIT; encoding is implementation choice; illegal states SHALL return to IDLE.
REQ-017 IDLE: when any i_Req_Valid bit is high and i_Tx_Busy is low, pick a winner round-robin starting at index (rr_ptr+1) mod 4, register it into o_Grant_Id, set o_Grant_Valid, clear burst count, go to SEND next cycle.
REQ-018 IDLE with no valid or with i_Tx_Busy high: stay in IDLE, no grant.
REQ-019 o_Req_Ready[g] SHALL be high only in SEND, for the granted index g, combinationally from state; all other bits zero.
REQ-020 SEND with i_Req_Valid[g] high: capture byte into o_Tx_Byte and i_Req_Last[g] into an internal flag, pulse o_Tx_Start on the next cycle, increment burst count, go to WAIT.
REQ-021 SEND with i_Req_Valid[g] low (requester withdrew mid-packet): release grant, set rr_ptr=g, go to IDLE; no o_Tx_Start.
REQ-022 Latency: valid asserted in IDLE at cycle 0 with Tx idle -> o_Grant_Valid and o_Req_Ready at cycle 1 -> o_Tx_Start at cycle 2.
REQ-023 o_Tx_Byte SHALL hold its value from o_Tx_Start until the next capture.
REQ-024 WAIT: on i_Tx_Done, if captured last flag is 1 or burst count equals MAX_BURST, set rr_ptr=g, clear o_Grant_Valid, go to IDLE; otherwise go to SEND keeping the grant.
REQ-025 WAIT: i_Tx_Done in the same cycle as o_Tx_Start SHALL be ignored.
REQ-026 WAIT: a 16-bit cycle counter starts at o_Tx_Start; if it reaches DONE_TIMEOUT without i_Tx_Done, pulse o_Timeout, set rr_ptr=g, release grant, go to IDLE.
REQ-027 Burst count 8 bits, saturating at MAX_BURST; never wraps.
REQ-028 Grant changes only in IDLE; a requester raising valid mid-burst of another waits for release.
REQ-029 After releasing requester g, requester g SHALL be lowest priority at the next arbitration.

Reset
REQ-030 On reset_n low: state IDLE, rr_ptr=3 (requester 0 highest priority first), o_Req_Ready=0, o_Tx_Start=0, o_Tx_Byte=8'h00, o_Grant_Valid=0, o_Grant_Id=0, o_Timeout=0, counters cleared.
REQ-031 Reset asserted mid-transfer SHALL abort immediately with no further o_Tx_Start; arbitration restarts from REQ-030 values.

Verification
REQ-032 Single byte: req1 valid data 8'hA5 last=1 -> grant 1 at cycle 1, ready[1] one cycle, o_Tx_Start at cycle 2 with o_Tx_Byte=8'hA5, release after i_Tx_Done.
REQ-033 Fairness: all four valid with last=1 every byte -> grant order 0,1,2,3,0 over five transfers.
REQ-034 Burst cap: req2 streams 12 bytes last=0, MAX_BURST=8 -> 8 o_Tx_Start pulses, release, req2 regranted only if no other valid.
REQ-035 Timeout: DONE_TIMEOUT=10, i_Tx_Done never arrives -> o_Timeout pulse 10 cycles after o_Tx_Start, grant released.
REQ-036 Withdrawal and busy: req3 drops valid in SEND -> IDLE, no start; i_Tx_Busy high in IDLE with valid pending -> no grant until busy falls.
REQ-037 Reset mid-WAIT -> all outputs at reset values next cycle, no o_Tx_Start after reset release until a new grant.
